// File: rtl/adiv5_arbiter_if.sv
// rtl/adiv5_arbiter_if.sv - requester and adiv5_mux FIFO-pair signals of the ADIv5 arbiter
interface adiv5_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int CMD_W  = 35,
  parameter int RESP_W = 35,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // requester side
  logic [NREQ-1:0]       REQ_REQ;
  logic [NREQ-1:0]       REQ_LOCK;
  logic [NREQ*CMD_W-1:0] REQ_WRDATA;
  logic [NREQ-1:0]       REQ_WREN;
  logic [NREQ-1:0]       REQ_WRFULL;
  logic [RESP_W-1:0]     REQ_RDDATA;
  logic [NREQ-1:0]       REQ_RDEN;
  logic [NREQ-1:0]       REQ_RDEMPTY;
  logic [NREQ-1:0]       GRANT;
  logic [CW-1:0]         OUTSTANDING;

  // adiv5_mux side
  logic [CMD_W-1:0]      ADIv5_WRDATA;
  logic                  ADIv5_WREN;
  logic                  ADIv5_WRFULL;
  logic [RESP_W-1:0]     ADIv5_RDDATA;
  logic                  ADIv5_RDEN;
  logic                  ADIv5_RDEMPTY;

  // arbiter view
  modport slave (
    input  REQ_REQ, REQ_LOCK, REQ_WRDATA, REQ_WREN, REQ_RDEN,
    output REQ_WRFULL, REQ_RDDATA, REQ_RDEMPTY, GRANT, OUTSTANDING,
    output ADIv5_WRDATA, ADIv5_WREN, ADIv5_RDEN,
    input  ADIv5_WRFULL, ADIv5_RDDATA, ADIv5_RDEMPTY
  );

  // requesters plus downstream FIFO pair view
  modport master (
    output REQ_REQ, REQ_LOCK, REQ_WRDATA, REQ_WREN, REQ_RDEN,
    input  REQ_WRFULL, REQ_RDDATA, REQ_RDEMPTY, GRANT, OUTSTANDING,
    input  ADIv5_WRDATA, ADIv5_WREN, ADIv5_RDEN,
    output ADIv5_WRFULL, ADIv5_RDDATA, ADIv5_RDEMPTY
  );
endinterface

// File: rtl/adiv5_arbiter.sv
// rtl/adiv5_arbiter.sv - round-robin/lockable sharing of the ADIv5 command/response FIFO pair
module adiv5_arbiter #(
  parameter int NREQ   = 2,
  parameter int CMD_W  = 35,
  parameter int RESP_W = 35,
  parameter int DEPTH  = 8
) (
  input logic CLK,
  input logic RESETn,
  adiv5_arbiter_if.slave bus
);
  localparam int TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [TAG_W-1:0]  gidx_q, gidx_d;
  logic [TAG_W-1:0]  rr_q, rr_d;

  // tag FIFO: issuer index of every accepted command, in command order
  logic [TAG_W-1:0]  tag_mem [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic              tag_full, tag_empty;
  logic [TAG_W-1:0]  head;

  logic              push, pop;
  logic [NREQ-1:0]   wrfull, rdempty;
  logic              others_waiting;
  logic              pick_found;
  logic [TAG_W-1:0]  pick_idx;
  int                scan_idx;

  assign tag_full  = (count_q == CW'(DEPTH));
  assign tag_empty = (count_q == '0);
  assign head      = tag_mem[rptr_q];

  // first requester at or after the round-robin pointer
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_q;
    scan_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_q) + k) % NREQ;
      if (!pick_found && bus.REQ_REQ[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = TAG_W'(scan_idx);
      end
    end
  end

  // command path: only the registered owner sees a non-full FIFO
  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      wrfull[j] = !grant_q[j] | bus.ADIv5_WRFULL | tag_full;
    end
    push = bus.REQ_WREN[gidx_q] & ~wrfull[gidx_q];
  end

  // response path: only the issuer recorded at the tag head may pop
  always_comb begin
    for (int j = 0; j < NREQ; j++) begin
      rdempty[j] = bus.ADIv5_RDEMPTY | tag_empty | (head != TAG_W'(j));
    end
    pop = bus.REQ_RDEN[head] & ~rdempty[head];
  end

  assign others_waiting   = |(bus.REQ_REQ & ~grant_q);

  assign bus.REQ_WRFULL   = wrfull;
  assign bus.REQ_RDEMPTY  = rdempty;
  assign bus.REQ_RDDATA   = bus.ADIv5_RDDATA;
  assign bus.ADIv5_WRDATA = bus.REQ_WRDATA[gidx_q*CMD_W +: CMD_W];
  assign bus.ADIv5_WREN   = push;
  assign bus.ADIv5_RDEN   = pop;
  assign bus.GRANT        = grant_q;
  assign bus.OUTSTANDING  = count_q;

  // grant FSM next state: release always passes through IDLE for one cycle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_OWNED;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
        end
      end
      ST_OWNED: begin
        if (!bus.REQ_REQ[gidx_q] ||
            (push && !bus.REQ_LOCK[gidx_q] && others_waiting)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = TAG_W'((int'(gidx_q) + 1) % NREQ);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // grant FSM state register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
    end
  end

  // tag storage; validity is tracked by the counter, so no reset needed
  always_ff @(posedge CLK) begin
    if (push) begin
      tag_mem[wptr_q] <= gidx_q;
    end
  end

  // tag FIFO pointers and outstanding count
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
